pe_rr_arbiter: RTL and testbench

//  Parametrised, registered successor to the 8-to-3 priority encoder.
//  - Encodes N request lines into a winner index plus a one-hot grant.
//  - Operates in fixed-priority mode (highest index wins) or round-robin mode.
//  - Presents the winner on a valid/ready handshake and holds it until accepted.
//  - Sits between request sources and a shared resource (bus or port arbitration).

---
 rtl/pe_pkg.sv | 6 +
 rtl/pe_fixed.sv | 18 +
 rtl/pe_rr_arbiter.sv | 63 ++++++
 tb/tb_pe_rr_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared state type and mode encodings for the priority-encoder arbiter
package pe_pkg;
  typedef enum logic {PE_IDLE, PE_GRANT} pe_state_t;
  localparam logic PE_FIXED = 1'b0;
  localparam logic PE_RR = 1'b1;
endpackage

// File: rtl/pe_fixed.sv
// pe_fixed: combinational highest-index encoder, req -> {any, idx}
module pe_fixed
  import pe_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);
  // scan upward so the highest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = req[i] ? W'(i) : idx;
  end
  assign any = |req;
endmodule

// File: rtl/pe_rr_arbiter.sv
// pe_rr_arbiter: registered fixed/round-robin arbiter with valid/ready grant hold
module pe_rr_arbiter
  import pe_pkg::*;
#(
  parameter int   N        = 8,
  parameter logic RR_RESET = 1'b0,
  localparam int  W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_en,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_oh
);
  pe_state_t    state, state_n;
  logic [W-1:0] ptr, ptr_n, ptr_dec, idx_n, m_idx, u_idx, win;
  logic         mode, mode_n, accept, load, m_any, u_any;
  logic [N-1:0] mask;
  assign gnt_valid = state == PE_GRANT;
  // pointer and mode updates; an rr accept moves the pointer just below the consumed index
  always_comb begin
    accept  = gnt_valid && gnt_ready;
    ptr_dec = gnt_idx == '0 ? W'(N - 1) : gnt_idx - 1'b1;
    ptr_n   = accept && mode == PE_RR ? ptr_dec : ptr;
    mode_n  = state == PE_IDLE ? rr_en : mode;
  end
  // rr candidates: requesters at or below the already-updated pointer
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = W'(i) <= ptr_n;
  end
  pe_fixed #(.N(N)) u_masked (.req(req & mask), .any(m_any), .idx(m_idx));
  pe_fixed #(.N(N)) u_full   (.req(req),        .any(u_any), .idx(u_idx));
  // winner selection and FSM; a new winner is captured from IDLE or on accept, never otherwise
  always_comb begin
    load    = state == PE_IDLE || accept;
    win     = mode_n == PE_RR && m_any ? m_idx : u_idx;
    state_n = load ? (u_any ? PE_GRANT : PE_IDLE) : state;
    idx_n   = load && u_any ? win : gnt_idx;
  end
  // state, pointer, mode and index registers; reset clears them immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PE_IDLE;
      ptr     <= W'(N - 1);
      mode    <= RR_RESET;
      gnt_idx <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      mode    <= mode_n;
      gnt_idx <= idx_n;
    end
  end
  // one-hot decode of the held index, silent outside GRANT
  always_comb begin
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = gnt_valid;
  end
endmodule

// File: tb/tb_pe_rr_arbiter.sv
// tb_pe_rr_arbiter: directed vectors with a behavioural reference model
module tb_pe_rr_arbiter;
  localparam int N = 8;
  logic         clk = 0;
  logic         rst_n = 1;
  logic [N-1:0] req = '0;
  logic         rr_en = 0;
  logic         gnt_ready = 0;
  logic         gnt_valid;
  logic [2:0]   gnt_idx;
  logic [N-1:0] gnt_oh;
  int errors = 0;
  int checks = 0;
  int mv = 0, mi = 0, mp = N - 1, mm = 0;
  int p;
  int md;
  pe_rr_arbiter #(.N(N), .RR_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en), .gnt_ready(gnt_ready),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_oh(gnt_oh)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // rr: walk down from the pointer, wrapping past 0 to N-1; fixed: walk down from N-1
  function automatic int pick(input logic [N-1:0] r, input int rr, input int pt);
    for (int k = 0; k < N; k++) begin
      int i = rr != 0 ? (pt - k + N) % N : N - 1 - k;
      if (r[i]) return i;
    end
    return 0;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 0; mi <= 0; mp <= N - 1; mm <= 0;
    end else begin
      md = mv != 0 ? mm : int'(rr_en);
      p  = (mv != 0 && gnt_ready && mm != 0) ? (mi + N - 1) % N : mp;
      mm <= md;
      mp <= p;
      if (mv == 0 || gnt_ready) begin
        mv <= req != 0 ? 1 : 0;
        if (req != 0) mi <= pick(req, md, p);
      end
    end
  end
  always @(negedge clk) begin
    chk("valid", int'(gnt_valid), mv);
    chk("onehot", int'(gnt_oh), mv != 0 ? (1 << mi) : 0);
    if (mv != 0) chk("idx", int'(gnt_idx), mi);
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic lit(input string name, input int v, input int idx);
    chk({name, "_v"}, int'(gnt_valid), v);
    if (v != 0) chk({name, "_idx"}, int'(gnt_idx), idx);
    chk({name, "_oh"}, int'(gnt_oh), v != 0 ? (1 << idx) : 0);
  endtask
  int seq3[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  initial begin
    #1 rst_n = 0;
    tick();
    lit("reset", 0, 0);
    chk("reset_idx", int'(gnt_idx), 0);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      lit("idle_noreq", 0, 0);
    end
    req = 8'b0010_0110;
    tick();
    lit("t1_fixed", 1, 5);
    req = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      lit("t2_hold", 1, 5);
    end
    gnt_ready = 1;
    tick();
    lit("t2_b2b", 1, 0);
    req = '0;
    tick();
    lit("t2_idle", 0, 0);
    rr_en = 1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      lit("t3_rr", 1, seq3[k]);
    end
    req = 8'h08;
    tick();
    lit("t5_pre", 1, 3);
    gnt_ready = 0;
    rst_n = 0;
    #1;
    lit("t5_async", 0, 0);
    chk("t5_async_idx", int'(gnt_idx), 0);
    tick();
    req = 8'hFF;
    gnt_ready = 1;
    rst_n = 1;
    tick();
    lit("t5_after", 1, 7);
    req = 8'b1000_0001;
    tick();
    lit("t4_alt0", 1, 0);
    tick();
    lit("t4_alt1", 1, 7);
    tick();
    lit("t4_alt2", 1, 0);
    req = '0;
    tick();
    lit("t6_idle", 0, 0);
    rr_en = 0;
    gnt_ready = 0;
    req = 8'b1000_0001;
    tick();
    lit("t6_fixed", 1, 7);
    rr_en = 1;
    gnt_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      lit("t6_locked_fixed", 1, 7);
    end
    req = '0;
    tick();
    lit("t6_idle2", 0, 0);
    req = 8'b1000_0001;
    tick();
    lit("t6_rr", 1, 7);
    rr_en = 0;
    tick();
    lit("t6_locked_rr0", 1, 0);
    tick();
    lit("t6_locked_rr1", 1, 7);
    req = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      lit("t6_noreq", 0, 0);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
